// File: rtl/polyphase_input_demux.sv
// polyphase_input_demux: 1:PHASES serial-to-parallel splitter at the filter input.
// Each accepted signed sample fills one lane. The last sample of a group is
// registered together with the earlier lanes into out_data.
// Optional feature macro: SYNC_IN_EN. It adds sync_in realignment and the
// resync_drop pulse. When the macro is undefined, sync_in is ignored.
//
// Handshake semantics, which apply to both ports: a transfer happens on a rising
// clk edge where valid and ready are both 1. While valid is 1 and ready is 0,
// the producer holds valid and its data stable. ready may depend
// combinationally on the consumer's own state and on the downstream ready.
// in_ready never depends on in_valid.
module polyphase_input_demux #(
    parameter int WIDTH  = 11,
    parameter int PHASES = 3,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PHASES*WIDTH-1:0] out_data,
    output logic                    out_phase0_first,
    output logic [CNT_W-1:0]        group_cnt,
    input  logic                    sync_in
`ifdef SYNC_IN_EN
    ,
    output logic                    resync_drop
`endif
);

    localparam int PH_W = (PHASES > 2) ? $clog2(PHASES) : 1;
    localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(PHASES - 1);

    logic [PH_W-1:0]          phase;
    logic [WIDTH-1:0]         lane [PHASES-1];
    logic                     first_flag;
    logic [PHASES*WIDTH-1:0]  next_group;
    logic                     accept;
    logic                     out_hs;
    logic                     do_sync;
    logic                     load;

`ifdef SYNC_IN_EN
    assign do_sync = accept & sync_in;
`else
    logic unused_sync;
    assign unused_sync = sync_in;
    assign do_sync     = 1'b0;
`endif

    // The last lane can only be loaded when the output register is free or draining this cycle.
    assign in_ready = reset & ((phase != LAST_PHASE) | ~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign out_hs   = out_valid & out_ready;
    assign load     = accept & ~do_sync & (phase == LAST_PHASE);

    // Assemble the parallel word: stored lanes below, the incoming sample in the top lane.
    always_comb begin
        next_group = '0;
        for (int k = 0; k < PHASES - 1; k++) begin
            next_group[k*WIDTH +: WIDTH] = lane[k];
        end
        next_group[(PHASES-1)*WIDTH +: WIDTH] = in_data;
    end

    // Phase counter, assembly lanes, output register and group counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase            <= '0;
            first_flag       <= 1'b1;
            out_valid        <= 1'b0;
            out_data         <= '0;
            out_phase0_first <= 1'b0;
            group_cnt        <= '0;
            for (int k = 0; k < PHASES - 1; k++) begin
                lane[k] <= '0;
            end
        end else begin
            if (out_hs) begin
                group_cnt <= group_cnt + 1'b1;
            end

            // A new group takes priority over clearing valid, so back-to-back groups have no bubble.
            if (load) begin
                out_valid        <= 1'b1;
                out_data         <= next_group;
                out_phase0_first <= first_flag;
                first_flag       <= 1'b0;
            end else if (out_hs) begin
                out_valid <= 1'b0;
            end

            if (do_sync) begin
                // Realign: this sample becomes lane 0 of a fresh group.
                lane[0]    <= in_data;
                phase      <= PH_W'(1);
                first_flag <= 1'b1;
            end else if (accept) begin
                if (phase == LAST_PHASE) begin
                    phase <= '0;
                end else begin
                    for (int k = 0; k < PHASES - 1; k++) begin
                        if (phase == PH_W'(k)) begin
                            lane[k] <= in_data;
                        end
                    end
                    phase <= phase + 1'b1;
                end
            end
        end
    end

`ifdef SYNC_IN_EN
    // One-cycle pulse when a sync throws away a partially filled group.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resync_drop <= 1'b0;
        end else begin
            resync_drop <= do_sync & (phase != '0);
        end
    end
`endif

endmodule

// File: tb/tb_polyphase_input_demux.sv
// tb_polyphase_input_demux: directed test-plan steps followed by random traffic.
// A queue-based reference model runs alongside the DUT.
// Optional feature macro: SYNC_IN_EN, which adds the resync steps.
module tb_polyphase_input_demux;

    localparam int W  = 11;
    localparam int P  = 3;
    localparam int CW = 16;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [P*W-1:0] out_data;
    logic           out_phase0_first;
    logic [CW-1:0]  group_cnt;
    logic           sync_in;
`ifdef SYNC_IN_EN
    logic           resync_drop;
`endif

    int checks   = 0;
    int failures = 0;

    polyphase_input_demux #(.WIDTH(W), .PHASES(P), .CNT_W(CW)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_phase0_first (out_phase0_first),
        .group_cnt        (group_cnt),
        .sync_in          (sync_in)
`ifdef SYNC_IN_EN
        ,
        .resync_drop      (resync_drop)
`endif
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [P*W-1:0] grp(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] c);
        return {c, b, a};
    endfunction

    // Reference model. It holds the samples of the group being collected and
    // the group currently presented. It also holds the expected groups.
    logic [W-1:0]   in_q  [$];
    logic [P*W-1:0] exp_q [$];
    logic [P*W-1:0] m_group;
    logic           m_pending;
    logic           m_first_out;
    logic           m_first;
    logic [CW-1:0]  m_cnt;
    logic           m_drop;

    always @(posedge clk or negedge reset) begin
        logic exp_ready;
        logic hs;
        logic acc;
        logic [P*W-1:0] g;
        if (!reset) begin
            in_q.delete();
            exp_q.delete();
            m_group     = '0;
            m_pending   = 1'b0;
            m_first_out = 1'b0;
            m_first     = 1'b1;
            m_cnt       = '0;
            m_drop      = 1'b0;
        end else begin
            exp_ready = (in_q.size() != P - 1) || !m_pending || out_ready;
            check("in_ready", in_ready, exp_ready);
            hs     = m_pending && out_ready;
            acc    = in_valid && exp_ready;
            m_drop = 1'b0;
            if (hs) begin
                m_cnt     = m_cnt + 1'b1;
                m_pending = 1'b0;
                void'(exp_q.pop_front());
            end
            if (acc) begin
`ifdef SYNC_IN_EN
                if (sync_in) begin
                    m_drop = (in_q.size() != 0);
                    in_q.delete();
                    m_first = 1'b1;
                end
`endif
                in_q.push_back(in_data);
                if (in_q.size() == P) begin
                    for (int k = 0; k < P; k++) g[k*W +: W] = in_q[k];
                    in_q.delete();
                    exp_q.push_back(g);
                    m_group     = g;
                    m_pending   = 1'b1;
                    m_first_out = m_first;
                    m_first     = 1'b0;
                end
            end
        end
    end

    // Scoreboard: compare registered outputs every cycle, away from the active edge.
    always @(negedge clk) begin
        check("mon_out_valid", out_valid, m_pending);
        check("mon_out_data", out_data, m_group);
        check("mon_phase0_first", out_phase0_first, m_first_out);
        check("mon_group_cnt", group_cnt, m_cnt);
        if (m_pending) check("mon_exp_q_head", out_data, exp_q[0]);
`ifdef SYNC_IN_EN
        check("mon_resync_drop", resync_drop, m_drop);
`endif
    end

    // Driver: inputs change at the falling edge and are held for one full clock.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic s);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        sync_in   = s;
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        sync_in   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_group_cnt", group_cnt, '0);
        check("rst_phase0_first", out_phase0_first, 1'b0);
        reset = 1'b1;

        // Streaming 1..6 with the consumer always ready.
        drive(1, 11'd1, 1, 0);
        drive(1, 11'd2, 1, 0);
        check("s1_no_early_valid", out_valid, 1'b0);
        drive(1, 11'd3, 1, 0);
        check("s1_valid", out_valid, 1'b1);
        check("s1_data", out_data, grp(11'd1, 11'd2, 11'd3));
        check("s1_first", out_phase0_first, 1'b1);
        check("s1_cnt", group_cnt, 16'd0);
        drive(1, 11'd4, 1, 0);
        check("s1_drained", out_valid, 1'b0);
        check("s1_cnt1", group_cnt, 16'd1);
        drive(1, 11'd5, 1, 0);
        drive(1, 11'd6, 1, 0);
        check("s2_data", out_data, grp(11'd4, 11'd5, 11'd6));
        check("s2_first", out_phase0_first, 1'b0);
        drive(0, 11'd0, 1, 0);
        check("s2_cnt2", group_cnt, 16'd2);

        // Signed extremes pass through unmodified.
        drive(1, 11'h400, 0, 0);
        drive(1, 11'h3FF, 0, 0);
        drive(1, 11'h000, 0, 0);
        check("ext_lane0", out_data[0 +: W], 11'h400);
        check("ext_lane1", out_data[W +: W], 11'h3FF);
        check("ext_lane2", out_data[2*W +: W], 11'h000);

        // Backpressure: lanes 0..1 are accepted while the last lane stalls.
        drive(1, 11'd4, 0, 0);
        drive(1, 11'd5, 0, 0);
        in_valid = 1'b1; in_data = 11'd6; out_ready = 1'b0;
        #1 check("bp_stall", in_ready, 1'b0);
        @(negedge clk);
        check("bp_hold_valid", out_valid, 1'b1);
        check("bp_hold_data", out_data, grp(11'h400, 11'h3FF, 11'h000));
        check("bp_still_stalled", in_ready, 1'b0);
        drive(1, 11'd6, 1, 0);
        check("bp_new_valid", out_valid, 1'b1);
        check("bp_new_data", out_data, grp(11'd4, 11'd5, 11'd6));
        check("bp_cnt", group_cnt, 16'd3);

        // Gaps in in_valid freeze the phase.
        drive(1, 11'd7, 1, 0);
        check("gap_v0", out_valid, 1'b0);
        drive(0, 11'd99, 0, 0);
        drive(0, 11'd98, 0, 0);
        drive(1, 11'd8, 0, 0);
        drive(0, 11'd97, 0, 0);
        check("gap_v1", out_valid, 1'b0);
        drive(1, 11'd9, 0, 0);
        check("gap_data", out_data, grp(11'd7, 11'd8, 11'd9));
        check("gap_cnt", group_cnt, 16'd4);

        // Reset mid-group with a pending word.
        drive(1, 11'd20, 0, 0);
        drive(1, 11'd21, 0, 0);
        #2 reset = 1'b0;
        #1;
        check("mrst_valid", out_valid, 1'b0);
        check("mrst_data", out_data, '0);
        check("mrst_cnt", group_cnt, '0);
        check("mrst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 11'd10, 0, 0);
        drive(1, 11'd11, 0, 0);
        drive(1, 11'd12, 0, 0);
        check("mrst_group", out_data, grp(11'd10, 11'd11, 11'd12));
        check("mrst_first", out_phase0_first, 1'b1);

`ifdef SYNC_IN_EN
        // Resync discards the partial group {1,2}.
        drive(1, 11'd1, 1, 0);
        drive(1, 11'd2, 1, 0);
        drive(1, 11'd3, 1, 1);
        check("sync_drop_pulse", resync_drop, 1'b1);
        drive(1, 11'd4, 1, 0);
        check("sync_drop_clear", resync_drop, 1'b0);
        drive(1, 11'd5, 1, 0);
        check("sync_group", out_data, grp(11'd3, 11'd4, 11'd5));
        check("sync_first", out_phase0_first, 1'b1);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), W'($urandom_range(0, (1 << W) - 1)),
                  1'($urandom_range(0, 2) != 0),
`ifdef SYNC_IN_EN
                  1'($urandom_range(0, 15) == 0)
`else
                  1'($urandom_range(0, 1))
`endif
                  );
        end
        for (int i = 0; i < 5; i++) drive(0, '0, 1, 0);
        check("drain_idle", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/polyphase_input_demux.md
Name: polyphase_input_demux

Overview:
- Single-clock 1:PHASES serial-to-parallel polyphase splitter at the filter input; the counterpart of the output serializing mux.
- Accepts one signed sample per accepted handshake at the full sample rate.
- Assembles groups of PHASES consecutive samples and presents each group as one parallel word with a valid/ready handshake.
- Downstream consumers are the per-phase FIR/IIR sections, which run on the group strobe.

Parameters:
WIDTH, 11, sample width in bits (signed two's complement)
PHASES, 3, samples per group (decimation factor), legal range 2..8
CNT_W, 16, width of the group counter

Ports:
clk  input  1  sample-rate clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
in_valid  input  1  input sample valid
in_ready  output  1  demux can accept a sample this cycle
in_data  input  WIDTH  signed input sample
out_valid  output  1  parallel group valid
out_ready  input  1  consumer accepts the group this cycle
out_data  output  PHASES*WIDTH  group; lane k = bits [k*WIDTH +: WIDTH]; lane 0 = earliest sample
out_phase0_first  output  1  high with the first group after reset or resync
group_cnt  output  CNT_W  number of groups delivered (out handshakes), wraps
sync_in  input  1  start-of-stream marker; used only when SYNC_IN_EN is defined, otherwise ignored

Behaviour:
- Reset (reset=0, asynchronous) clears the following:
  - phase counter set to 0;
  - assembly lanes set to 0;
  - out_valid=0, out_data=0, out_phase0_first=0, group_cnt=0;
  - internal first flag set to 1.
- in_ready is combinational. It is 0 during reset. Otherwise in_ready = (phase != PHASES-1) | !out_valid | out_ready.
- Input accept = in_valid & in_ready.
- On accept with phase < PHASES-1:
  - assembly lane[phase] <= in_data;
  - phase increments by 1.
- On accept with phase == PHASES-1:
  - out_data <= {in_data, lane[PHASES-2], ..., lane[0]};
  - out_valid <= 1;
  - out_phase0_first <= first flag, then first flag <= 0;
  - phase <= 0.
- Latency: out_valid rises on the clock edge after the last sample of a group is accepted (1 cycle).
- Output handshake = out_valid & out_ready.
  - On handshake with no new group loading: out_valid <= 0.
  - On handshake, group_cnt increments by 1, modulo 2^CNT_W.
- Simultaneous handshake and load of a new group: out_valid stays 1, out_data takes the new group, group_cnt still increments. Full throughput is one sample per clk with no bubbles.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data and out_phase0_first are held stable.
  - In that state, samples for lanes 0..PHASES-2 are still accepted.
  - The last sample of the next group stalls (in_ready=0) until out_ready=1.
- in_valid=0 cycles freeze the phase counter. Partial groups are never emitted or discarded; there is no timeout.
- Asserting reset mid-group discards the partial group and any pending output word. There is no output glitch beyond the asynchronous clear.
- Samples are passed unmodified; no arithmetic and no saturation.

Optional Feature:
- Macro: SYNC_IN_EN.
- Defined, sync_in is sampled only when an input is accepted. Accept with sync_in=1:
  - discards any partial group (phase forced to 0);
  - writes in_data into lane 0 and sets phase to 1;
  - sets the first flag, so the group completed from this sample carries out_phase0_first=1;
  - does not disturb a pending output word.
- Defined, a 1-cycle pulse output resync_drop is added. It is high on the edge after a sync discards a non-empty partial group (phase != 0).
- Not defined: sync_in is ignored, resync_drop does not exist, and phase is aligned only by reset.

Test Plan:
- Reset release, out_ready=1, stream in_data=1,2,3,4,5,6 on consecutive clocks:
  - out_valid on cycles 4 and 7;
  - out_data lanes {1,2,3}, then {4,5,6};
  - out_phase0_first=1 on the first group only;
  - group_cnt 0->1->2.
- Signed extremes: feed -1024, 1023, 0 -> lanes read 0x400, 0x3FF, 0x000 exactly.
- Backpressure: out_ready=0 after the first group, stream 4,5,6:
  - 4 and 5 are accepted;
  - in_ready=0 on the cycle 6 is presented;
  - {1,2,3} is held stable;
  - after releasing out_ready, {4,5,6} appears one cycle after 6 is accepted.
- Gaps: in_valid toggling 1,0,0,1,0,1 with data 7,8,9 -> single group {7,8,9}, no early out_valid.
- Reset asserted after 2 samples of a group: all outputs clear immediately; the next samples 10,11,12 form group {10,11,12} with out_phase0_first=1.
- SYNC_IN_EN: stream 1,2, then 3 with sync_in=1, then 4,5:
  - resync_drop pulses once;
  - the next group is {3,4,5} with out_phase0_first=1.
